// File: rtl/uart_top.sv
// uart_top: transmit-only UART that serialises one byte per tx_start request.
// The default build sends 8N1 frames. Defining UART_TX_PARITY_EN adds an
// even-parity bit after the data bits, which makes the frames 8E1.
// Each bit lasts BAUD_DIV clock cycles. tx and tx_busy are both registered.
module uart_top #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic [CW-1:0] baud_cnt;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  // The current bit time ends on the last baud count.
  assign bit_end = (baud_cnt == LAST);

  // Frame sequencer. The line level for each bit is registered on the same
  // edge that starts the bit, so tx switches exactly at the bit boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      if (state == IDLE) begin
        baud_cnt <= '0;
      end else if (bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            shreg   <= tx_data;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= ^tx_data;
`endif
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (bit_end) begin
            // Present bit 0 now. The shift leaves the next bit ready in shreg[0].
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_top.sv
// Testbench for uart_top. It uses a small BAUD_DIV to keep run time short.
// It builds the same way as the RTL with and without UART_TX_PARITY_EN.
module tb_uart_top;

  localparam int D = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_top #(.CLK_FREQ(1600), .BAUD(100), .BAUD_DIV(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx       (tx)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // 8N1 line levels, bit 0 = start bit
    logic       par;    // even-parity bit of data
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame built from the serial format rules: start 0, data LSB
  // first, optional even parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = d[i];
      if (d[i]) ones++;
    end
`ifdef UART_TX_PARITY_EN
    f[9] = (ones % 2 == 1);
`endif
    return f;
  endfunction

  function automatic logic [10:0] expand(input logic [9:0] fr, input logic par);
`ifdef UART_TX_PARITY_EN
    return {1'b1, par, fr[8:0]};
`else
    return {1'b0, fr};
`endif
  endfunction

  // Called at #1 after the edge that accepted a frame. Checks every cycle of
  // every bit, and reports one comparison per bit.
  task automatic check_frame(input string name, input logic [10:0] bits,
                             input int inject_t, input bit hold,
                             input logic [7:0] next_data);
    logic [1:0] rec;
    logic [1:0] exp;
    int t;
    if (hold) tx_data = next_data;
    for (int b = 0; b < NB; b++) begin
      exp = {1'b1, bits[b]};
      rec = exp;
      for (int c = 0; c < D; c++) begin
        t = b * D + c;
        if (!hold) begin
          if (t == inject_t) begin
            tx_start = 1'b1;
            tx_data  = 8'hA5;
          end else begin
            tx_start = 1'b0;
            tx_data  = 8'($urandom);
          end
        end
        if ({tx_busy, tx} !== exp && rec === exp) rec = {tx_busy, tx};
        @(posedge clk); #1;
      end
      chk($sformatf("%s bit%0d", name, b), 32'(rec), 32'(exp));
    end
    chk({name, " end"}, 32'({tx_busy, tx}), 32'(2'b01));
  endtask

  task automatic idle_check(input string name, input int n);
    logic [1:0] rec;
    rec = 2'b01;
    tx_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if ({tx_busy, tx} !== 2'b01 && rec === 2'b01) rec = {tx_busy, tx};
      @(posedge clk); #1;
    end
    chk({name, " idle"}, 32'(rec), 32'(2'b01));
  endtask

  task automatic start_frame(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    vecs[0] = '{8'h31, 10'b1_00110001_0, 1'b1};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[3] = '{8'h55, 10'b1_01010101_0, 1'b0};
    vecs[4] = '{8'hAA, 10'b1_10101010_0, 1'b0};
    vecs[5] = '{8'h80, 10'b1_10000000_0, 1'b1};

    rst = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    #2 rst = 1'b1;
    #1 chk("reset async", 32'({tx_busy, tx}), 32'(2'b01));
    @(posedge clk); #1;
    chk("reset held", 32'({tx_busy, tx}), 32'(2'b01));
    rst = 1'b0;
    idle_check("post reset", 20);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].data);
      check_frame($sformatf("vec%0d", i), expand(vecs[i].frame, vecs[i].par), -1, 1'b0, 8'h00);
      idle_check($sformatf("vec%0d", i), 2);
    end

    // A request made while busy is ignored.
    start_frame(8'h31);
    check_frame("reject", expand(vecs[0].frame, vecs[0].par), NB * D / 2, 1'b0, 8'h00);
    idle_check("reject", 3 * D);

    // A held tx_start gives back-to-back frames with a one-cycle gap.
    start_frame(8'h55);
    check_frame("b2b0", expand(vecs[3].frame, vecs[3].par), -1, 1'b1, 8'hAA);
    @(posedge clk); #1;
    check_frame("b2b1", expand(vecs[4].frame, vecs[4].par), -1, 1'b0, 8'h00);
    idle_check("b2b", 2 * D);

    // Reset asserted mid-frame, during data bit 3.
    start_frame(8'h31);
    tx_start = 1'b0;
    for (int i = 0; i < 4 * D + D / 2; i++) begin
      @(posedge clk); #1;
    end
    chk("midframe bit3", 32'({tx_busy, tx}), 32'(2'b10));
    #2 rst = 1'b1;
    #1 chk("midframe abort", 32'({tx_busy, tx}), 32'(2'b01));
    @(posedge clk); #1;
    rst = 1'b0;
    idle_check("after abort", 5);
    start_frame(8'h31);
    check_frame("after abort", expand(vecs[0].frame, vecs[0].par), -1, 1'b0, 8'h00);

    // Random bytes checked against the reference model.
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      idle_check($sformatf("rnd%0d gap", i), 1 + int'($urandom_range(0, 3)));
      start_frame(d);
      check_frame($sformatf("rnd%0d", i), model_frame(d), -1, 1'b0, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
